// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, schedule sizes, S-box and xtime helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_t;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input key_len_t k);
        case (k)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t k);
        case (k)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input key_len_t k);
        case (k)
            KEY_192: return 6'd52;
            KEY_256: return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

endpackage

// File: rtl/aes_subword.sv
// 32-bit SubWord: four parallel S-box lookups, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock, round keys read by index.
// Optional feature: define AES_KEYSCHED_ZEROIZE_EN to add the zeroize input.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_WORDS = 60,
    parameter int IDX_W     = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [255:0]      key_in,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic              keys_valid,
    output logic [3:0]        nr,
    input  logic              rk_rd,
    input  logic [IDX_W-1:0]  rk_idx,
    output logic [127:0]      rk_out,
    output logic              rk_vld
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam logic [6:0] MAXW = 7'(MAX_WORDS);

    ks_state_t     state_q, state_d;
    key_len_t      klen_q, req_len;
    logic [AW-1:0] i_q, rd_base;
    logic [2:0]    j_q;
    logic [7:0]    rcon_q;
    logic [3:0]    nk_cur, nr_q;
    logic          kv_q, done_q, err_q;
    logic          zero_req, len_ok, accept, reject, last_word, rd_ok;
    logic [31:0]   w_prev, w_back, sub_in, sub_out, t_word;
    logic [31:0]   store [MAX_WORDS];

`ifdef AES_KEYSCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign req_len    = key_len_t'(key_len);
    assign len_ok     = (req_len != KEY_RSVD) && ({1'b0, nw_of(req_len)} <= MAXW);
    assign done       = done_q;
    assign err        = err_q;
    assign keys_valid = kv_q;
    assign nr         = nr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (zero_req)                                state_d = ST_IDLE;
        else if (state_q == ST_IDLE && accept)       state_d = ST_EXPAND;
        else if (state_q == ST_EXPAND && last_word)  state_d = ST_IDLE;
    end

    // Start is only looked at while idle; zeroize silences both accept and reject.
    always_comb begin
        ready     = (state_q == ST_IDLE);
        accept    = ready && start && len_ok && !zero_req;
        reject    = ready && start && !len_ok && !zero_req;
        last_word = (state_q == ST_EXPAND) && (i_q == AW'(nw_of(klen_q) - 6'd1));
    end

    // Single shared SubWord: rotated input on the Nk boundary, plain input for the AES-256 mid-word.
    always_comb begin
        nk_cur = nk_of(klen_q);
        w_prev = store[i_q - 1'b1];
        w_back = store[i_q - AW'(nk_cur)];
        sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (j_q == 3'd0)                           t_word = sub_out ^ {rcon_q, 24'h0};
        else if (klen_q == KEY_256 && j_q == 3'd4) t_word = sub_out;
        else                                       t_word = w_prev;
    end

    aes_subword u_subword (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klen_q <= KEY_128;
            i_q    <= '0;
            j_q    <= '0;
            rcon_q <= 8'h01;
            kv_q   <= 1'b0;
            nr_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= last_word && !zero_req;
            err_q  <= reject;
            if (zero_req) begin
                kv_q <= 1'b0;
                nr_q <= '0;
            end else if (accept) begin
                klen_q <= req_len;
                i_q    <= AW'(nk_of(req_len));
                j_q    <= '0;
                rcon_q <= 8'h01;
                kv_q   <= 1'b0;
                nr_q   <= '0;
            end else if (state_q == ST_EXPAND) begin
                i_q <= i_q + 1'b1;
                j_q <= (j_q == 3'(nk_cur - 4'd1)) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
                if (last_word) begin
                    kv_q <= 1'b1;
                    nr_q <= nr_of(klen_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_WORDS; k++) store[k] <= '0;
        end else if (zero_req) begin
            for (int k = 0; k < MAX_WORDS; k++) store[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_of(req_len))) store[k] <= key_in[255 - 32*k -: 32];
        end else if (state_q == ST_EXPAND) begin
            store[i_q] <= w_back ^ t_word;
        end
    end

    // A read in the accept cycle sees the schedule as already invalidated.
    assign rd_base = AW'({rk_idx, 2'b00});
    assign rd_ok   = rk_rd && kv_q && !accept && (int'(rk_idx) <= int'(nr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out <= '0;
            rk_vld <= 1'b0;
        end else if (zero_req) begin
            rk_out <= '0;
            rk_vld <= 1'b0;
        end else begin
            rk_vld <= rd_ok;
            if (rd_ok)
                rk_out <= {store[rd_base], store[rd_base + 1'b1],
                           store[rd_base + 2'd2], store[rd_base + 2'd3]};
        end
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, multi-length AES key expansion engine: accepts a 128/192/256-bit cipher key, generates one 32-bit schedule word per clock into an internal word store, and serves 128-bit round keys by index. Successor to the purely combinational AES-128 expander. Sits between key-load logic and the round datapath of the encryption core, trading ~40–52 cycles of latency for a single shared SubWord unit.

## Interface
Parameters:
- `MAX_WORDS`, 60: word-store depth (4·(Nr_max+1)); 44 limits the block to AES-128, 52 to AES-128/192.
- `IDX_W`, 4: width of round-key index.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request expansion; accepted only when `ready`=1.
- `key_len` in 2: 0=AES-128, 1=AES-192, 2=AES-256, 3=reserved; sampled with `start`.
- `key_in` in 256: key, MSB-aligned; word 0 = `key_in[255:224]`; unused low bits ignored.
- `ready` out 1: idle, start will be accepted.
- `done` out 1: one-cycle pulse when the last word is written.
- `err` out 1: one-cycle pulse on rejected start.
- `keys_valid` out 1: store holds a complete schedule.
- `nr` out 4: round count of the stored schedule (10/12/14), 0 when invalid.
- `rk_rd` in 1: round-key read strobe.
- `rk_idx` in IDX_W: round index 0..nr.
- `rk_out` out 128: round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, MSB first.
- `rk_vld` out 1: `rk_out` valid.

## Operation
- Nk = 4/6/8, Nr = 10/12/14, total words Nw = 4·(Nr+1) = 44/52/60.
- States: IDLE, EXPAND.
- IDLE: `ready`=1. On `start` with legal `key_len` (and Nw ≤ MAX_WORDS): write w[0..Nk-1] from `key_in`, clear `keys_valid`, set i=Nk, phase j=0, rcon=0x01, go EXPAND. Illegal `key_len` (3, or exceeding MAX_WORDS): `err` pulse, store and `keys_valid` untouched, stay IDLE.
- EXPAND: per cycle write w[i] = w[i−Nk] ^ t, with t = SubWord(RotWord(w[i−1])) ^ {rcon,24'h0} if j=0; SubWord(w[i−1]) if Nk=8 and j=4; else w[i−1]. After j=0 use, rcon ← xtime(rcon) (0x80→0x1B). j wraps Nk−1→0 (counter, no division). When i=Nw−1 is written: `done`=1, `keys_valid`=1, `nr`=Nr, go IDLE.
- `start` in EXPAND: ignored, no `err`.
- Read: `rk_rd` with `keys_valid`=1 and `rk_idx` ≤ `nr` → next cycle `rk_out`=key, `rk_vld`=1. Otherwise `rk_vld`=0, `rk_out` holds last value. Reads during EXPAND return `rk_vld`=0.

## Timing
- Reset: IDLE, `ready`=1, `done`=`err`=`keys_valid`=`rk_vld`=0, `nr`=0, `rk_out`=0, store contents 0.
- Start-accept cycle counts as load; EXPAND lasts Nw−Nk cycles: 40/46/52. `done` asserts in the cycle after the final EXPAND edge; `ready` high that same cycle. Back-to-back: `start` accepted in the `done` cycle.
- Read latency 1 cycle, one read per cycle, pipelined.
- Reset mid-EXPAND: immediate abort to reset state, no `done`.
- `start` and `rk_rd` in same IDLE cycle: read returns `rk_vld`=0 (keys_valid cleared by accept).

## Configuration
- `AES_KEYSCHED_ZEROIZE_EN`: defined → extra input `zeroize` (1 bit); when asserted in any state, next cycle all store words=0, `keys_valid`=0, `nr`=0, `rk_out`=0, state IDLE, no `done`; overrides simultaneous `start`. Undefined → port absent; store cleared only by `rst_n`.

## Structure
- Package `aes_pkg`: `key_len_t` enum, Nk/Nr/Nw constant functions, S-box function, `xtime` function, shared with cipher datapath.
- Sub-module `aes_subword`: 32-bit SubWord (four S-box lookups), combinational, single instance.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c → `done` 40 cycles after accept; read idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6, `nr`=10.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 46 cycles; idx 12 → e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 52 cycles; idx 14 → fe4890d1e6188d0b046df344706c631e; idx 15 → `rk_vld`=0.
- `key_len`=3 after valid AES-128 schedule → `err` pulse, `keys_valid` stays 1, idx 10 still reads d014f9a8….
- `rst_n` low at EXPAND cycle 20 → no `done`, `keys_valid`=0, all outputs at reset values; fresh start completes normally.
- (ZEROIZE_EN) `zeroize` with `start` mid-EXPAND → IDLE, `keys_valid`=0, read idx 0 → `rk_vld`=0.
